// File: rtl/h14tx_pkg.sv
// Shared types and helpers for the h14tx transmitter blocks.
package h14tx_pkg;

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StFilter,
        StRelease,
        StRun
    } rst_seq_state_e;

    localparam logic [7:0] EvtCntMax = 8'hFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/h14tx_sync.sv
// Two-flop synchroniser for asynchronous inputs, parametrised width.
module h14tx_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/h14tx_rst_seq.sv
// PLL lock supervisor and staged reset sequencer: pulses the PLL reset, filters lock,
// releases domain resets in order and re-asserts them on lock loss.
module h14tx_rst_seq
    import h14tx_pkg::*;
#(
    parameter int unsigned NumDomains   = 3,
    parameter int unsigned LockFilter   = 16,
    parameter int unsigned StageDelay   = 16,
    parameter int unsigned LockTimeout  = 65536,
    parameter int unsigned PllRstCycles = 8
) (
    input  logic                  ref_clk_i,
    input  logic                  rst_i,
    input  logic                  pll_lock_i,
    output logic                  pll_rst_o,
    output logic [NumDomains-1:0] domain_rst_n_o,
    output logic                  ready_o,
    output logic [7:0]            relock_cnt_o,
    output logic [7:0]            timeout_cnt_o
);

    localparam int unsigned CntW =
        $clog2(max_u(max_u(LockTimeout, LockFilter), max_u(StageDelay, PllRstCycles))) + 1;

    localparam logic [CntW-1:0] PllRstLast  = CntW'(PllRstCycles - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LockTimeout - 1);
    localparam logic [CntW-1:0] FilterLast  = CntW'(LockFilter - 1);
    localparam logic [CntW-1:0] StageLast   = CntW'(StageDelay - 1);

    rst_seq_state_e        state_q;
    logic [CntW-1:0]       cnt_q;
    logic                  pll_rst_q;
    logic [NumDomains-1:0] dom_q;
    logic                  ready_q;
    logic [7:0]            relock_q;
    logic [7:0]            timeout_q;

    logic                  lock_s;
    logic [NumDomains-1:0] dom_shift;

    h14tx_sync #(
        .Width (1)
    ) u_lock_sync (
        .clk_i (ref_clk_i),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    // Domains release as a thermometer code, so the next bit is always the next one up.
    assign dom_shift = NumDomains'({dom_q, 1'b1});

    // One counter is shared: every state transition restarts it from zero.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            relock_q  <= '0;
            timeout_q <= '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (cnt_q == PllRstLast) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_q <= StFilter;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        state_q   <= StPllRst;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (timeout_q != EvtCntMax) begin
                            timeout_q <= timeout_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFilter: begin
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == FilterLast) begin
                        dom_q <= dom_shift;
                        cnt_q <= '0;
                        if (dom_shift[NumDomains-1]) begin
                            state_q <= StRun;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= StRelease;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRelease, StRun: begin
                    // Lock loss takes priority over a pending stage release.
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                        dom_q   <= '0;
                        ready_q <= 1'b0;
                        if (relock_q != EvtCntMax) begin
                            relock_q <= relock_q + 8'd1;
                        end
                    end else if (state_q == StRelease) begin
                        if (cnt_q == StageLast) begin
                            dom_q <= dom_shift;
                            cnt_q <= '0;
                            if (dom_shift[NumDomains-1]) begin
                                state_q <= StRun;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StPllRst;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    dom_q     <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o      = pll_rst_q;
    assign domain_rst_n_o = dom_q;
    assign ready_o        = ready_q;
    assign relock_cnt_o   = relock_q;
    assign timeout_cnt_o  = timeout_q;

endmodule
